// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared Ascon round-count constants
package ascon_pkg;

  // Permutation lengths: p^a for init/final, p^b for AD/ciphertext blocks.
  localparam int P_ROUNDS_A = 12;
  localparam int P_ROUNDS_B = 6;

  // Every permutation ends on round index 11.
  // Shorter permutations start part-way through the round-constant table.
  localparam logic [3:0] ROUND_LAST      = 4'd11;
  localparam logic [3:0] ROUND_START_A   = 4'(12 - P_ROUNDS_A);
  localparam logic [3:0] ROUND_START_B   = 4'(12 - P_ROUNDS_B);
  localparam logic [3:0] ROUND_PROC_LAST = ROUND_LAST - 4'd1;

endpackage

// File: rtl/ascon_load_counter.sv
// rtl/ascon_load_counter.sv - loadable up-counter with enable
module ascon_load_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] count
);

  // Load has priority over increment; otherwise the count holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ascon_decrypt_fsm.sv
// rtl/ascon_decrypt_fsm.sv - Ascon-128 decryption control FSM
module ascon_decrypt_fsm #(
  parameter int P_NUM_CT_BLOCKS = 3,
  parameter int P_BLK_W         = $clog2(P_NUM_CT_BLOCKS + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_sys_enable,
  input  logic               i_start,
  input  logic               i_data_valid,
  input  logic               i_tag_match,
  output logic               o_ready,
  output logic               o_mux_select,
  output logic               o_enable_state_reg,
  output logic               o_enable_xor_data_begin,
  output logic               o_enable_replace_data_begin,
  output logic               o_enable_xor_key_begin,
  output logic               o_enable_xor_key_end,
  output logic               o_enable_xor_lsb_end,
  output logic               o_enable_plain_reg,
  output logic               o_valid_plain,
  output logic               o_enable_tag_reg,
  output logic [3:0]         o_round_count,
  output logic [P_BLK_W-1:0] o_block_count,
  output logic               o_done,
  output logic               o_auth_ok,
  output logic               o_auth_fail
);

  import ascon_pkg::*;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_START_INIT,
    ST_PROC_INIT,
    ST_END_INIT,
    ST_IDLE_AD,
    ST_START_AD,
    ST_PROC_AD,
    ST_END_AD,
    ST_IDLE_CT,
    ST_START_CT,
    ST_PROC_CT,
    ST_END_CT,
    ST_IDLE_FINAL,
    ST_START_FINAL,
    ST_PROC_FINAL,
    ST_END_FINAL,
    ST_CHECK_TAG
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       rc_load;
  logic [3:0] rc_load_value;
  logic       rc_enable;
  logic       bc_load;
  logic       bc_enable;

  logic       last_proc_round;
  logic       last_ct_block;
  logic       start_accept;

  assign last_proc_round = (o_round_count == ROUND_PROC_LAST);
  assign last_ct_block   = (o_block_count == P_BLK_W'(P_NUM_CT_BLOCKS));
  assign start_accept    = i_sys_enable && (state == ST_IDLE) && i_start;

  // State register; a low system enable overrides any computed transition.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else if (!i_sys_enable) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Moore decode of datapath enables and counter controls.
  always_comb begin
    state_next                  = state;
    o_ready                     = 1'b0;
    o_mux_select                = 1'b1;
    o_enable_state_reg          = 1'b0;
    o_enable_xor_data_begin     = 1'b0;
    o_enable_replace_data_begin = 1'b0;
    o_enable_xor_key_begin      = 1'b0;
    o_enable_xor_key_end        = 1'b0;
    o_enable_xor_lsb_end        = 1'b0;
    o_enable_plain_reg          = 1'b0;
    o_valid_plain               = 1'b0;
    o_enable_tag_reg            = 1'b0;
    o_done                      = 1'b0;
    rc_load                     = 1'b0;
    rc_load_value               = ROUND_START_A;
    rc_enable                   = 1'b0;
    bc_load                     = 1'b0;
    bc_enable                   = 1'b0;

    case (state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_start) state_next = ST_CONFIG;
      end

      ST_CONFIG: begin
        o_mux_select       = 1'b0;
        o_enable_state_reg = 1'b1;
        rc_load            = 1'b1;
        rc_load_value      = ROUND_START_A;
        state_next         = ST_START_INIT;
      end

      ST_START_INIT: begin
        o_enable_state_reg = 1'b1;
        rc_enable          = 1'b1;
        state_next         = ST_PROC_INIT;
      end

      ST_PROC_INIT: begin
        o_enable_state_reg = 1'b1;
        rc_enable          = 1'b1;
        if (last_proc_round) state_next = ST_END_INIT;
      end

      ST_END_INIT: begin
        o_enable_state_reg   = 1'b1;
        o_enable_xor_key_end = 1'b1;
        state_next           = ST_IDLE_AD;
      end

      ST_IDLE_AD: begin
        o_ready       = 1'b1;
        rc_load       = 1'b1;
        rc_load_value = ROUND_START_B;
        if (i_data_valid) state_next = ST_START_AD;
      end

      ST_START_AD: begin
        o_enable_state_reg      = 1'b1;
        o_enable_xor_data_begin = 1'b1;
        rc_enable               = 1'b1;
        state_next              = ST_PROC_AD;
      end

      ST_PROC_AD: begin
        o_enable_state_reg = 1'b1;
        rc_enable          = 1'b1;
        if (last_proc_round) state_next = ST_END_AD;
      end

      ST_END_AD: begin
        o_enable_state_reg   = 1'b1;
        o_enable_xor_lsb_end = 1'b1;
        bc_load              = 1'b1;
        state_next           = ST_IDLE_CT;
      end

      ST_IDLE_CT: begin
        o_ready       = 1'b1;
        rc_load       = 1'b1;
        rc_load_value = ROUND_START_B;
        if (i_data_valid) state_next = ST_START_CT;
      end

      ST_START_CT: begin
        o_enable_state_reg          = 1'b1;
        o_enable_replace_data_begin = 1'b1;
        o_enable_plain_reg          = 1'b1;
        o_valid_plain               = 1'b1;
        rc_enable                   = 1'b1;
        bc_enable                   = 1'b1;
        state_next                  = ST_PROC_CT;
      end

      ST_PROC_CT: begin
        o_enable_state_reg = 1'b1;
        rc_enable          = 1'b1;
        if (last_proc_round) state_next = ST_END_CT;
      end

      ST_END_CT: begin
        o_enable_state_reg = 1'b1;
        state_next         = last_ct_block ? ST_IDLE_FINAL : ST_IDLE_CT;
      end

      ST_IDLE_FINAL: begin
        o_ready       = 1'b1;
        rc_load       = 1'b1;
        rc_load_value = ROUND_START_A;
        if (i_data_valid) state_next = ST_START_FINAL;
      end

      ST_START_FINAL: begin
        o_enable_state_reg          = 1'b1;
        o_enable_replace_data_begin = 1'b1;
        o_enable_xor_key_begin      = 1'b1;
        o_enable_plain_reg          = 1'b1;
        o_valid_plain               = 1'b1;
        rc_enable                   = 1'b1;
        state_next                  = ST_PROC_FINAL;
      end

      ST_PROC_FINAL: begin
        o_enable_state_reg = 1'b1;
        rc_enable          = 1'b1;
        if (last_proc_round) state_next = ST_END_FINAL;
      end

      ST_END_FINAL: begin
        o_enable_state_reg   = 1'b1;
        o_enable_xor_key_end = 1'b1;
        o_enable_tag_reg     = 1'b1;
        state_next           = ST_CHECK_TAG;
      end

      ST_CHECK_TAG: begin
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sticky verdict: cleared by a new start or a system disable, set at tag check.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_auth_ok   <= 1'b0;
      o_auth_fail <= 1'b0;
    end else if (!i_sys_enable || start_accept) begin
      o_auth_ok   <= 1'b0;
      o_auth_fail <= 1'b0;
    end else if (state == ST_CHECK_TAG) begin
      o_auth_ok   <= i_tag_match;
      o_auth_fail <= !i_tag_match;
    end
  end

  ascon_load_counter #(
    .W(4)
  ) u_round_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (rc_load && i_sys_enable),
    .load_value (rc_load_value),
    .enable     (rc_enable && i_sys_enable),
    .count      (o_round_count)
  );

  ascon_load_counter #(
    .W(P_BLK_W)
  ) u_block_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (bc_load && i_sys_enable),
    .load_value ('0),
    .enable     (bc_enable && i_sys_enable),
    .count      (o_block_count)
  );

endmodule

// File: tb/tb_ascon_decrypt_fsm.sv
// tb/tb_ascon_decrypt_fsm.sv - scoreboard bench for ascon_decrypt_fsm
`timescale 1ns/1ps
module tb_ascon_decrypt_fsm;

  localparam int NB = 3;
  localparam int BW = $clog2(NB + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_sys_enable = 1'b0;
  logic          i_start = 1'b0;
  logic          i_data_valid = 1'b0;
  logic          i_tag_match = 1'b0;
  logic          o_ready;
  logic          o_mux_select;
  logic          o_enable_state_reg;
  logic          o_enable_xor_data_begin;
  logic          o_enable_replace_data_begin;
  logic          o_enable_xor_key_begin;
  logic          o_enable_xor_key_end;
  logic          o_enable_xor_lsb_end;
  logic          o_enable_plain_reg;
  logic          o_valid_plain;
  logic          o_enable_tag_reg;
  logic [3:0]    o_round_count;
  logic [BW-1:0] o_block_count;
  logic          o_done;
  logic          o_auth_ok;
  logic          o_auth_fail;

  ascon_decrypt_fsm #(
    .P_NUM_CT_BLOCKS(NB)
  ) dut (
    .clock                       (clock),
    .reset_n                     (reset_n),
    .i_sys_enable                (i_sys_enable),
    .i_start                     (i_start),
    .i_data_valid                (i_data_valid),
    .i_tag_match                 (i_tag_match),
    .o_ready                     (o_ready),
    .o_mux_select                (o_mux_select),
    .o_enable_state_reg          (o_enable_state_reg),
    .o_enable_xor_data_begin     (o_enable_xor_data_begin),
    .o_enable_replace_data_begin (o_enable_replace_data_begin),
    .o_enable_xor_key_begin      (o_enable_xor_key_begin),
    .o_enable_xor_key_end        (o_enable_xor_key_end),
    .o_enable_xor_lsb_end        (o_enable_xor_lsb_end),
    .o_enable_plain_reg          (o_enable_plain_reg),
    .o_valid_plain               (o_valid_plain),
    .o_enable_tag_reg            (o_enable_tag_reg),
    .o_round_count               (o_round_count),
    .o_block_count               (o_block_count),
    .o_done                      (o_done),
    .o_auth_ok                   (o_auth_ok),
    .o_auth_fail                 (o_auth_fail)
  );

  logic [12:0] out_vec;
  assign out_vec = {o_mux_select, o_enable_state_reg, o_enable_xor_data_begin,
                    o_enable_replace_data_begin, o_enable_xor_key_begin,
                    o_enable_xor_key_end, o_enable_xor_lsb_end, o_enable_plain_reg,
                    o_valid_plain, o_enable_tag_reg, o_done, o_auth_ok, o_auth_fail};

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int   kind;
    int   at;
    logic ok;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic pend_verdict = 1'b0;
  logic pend_ok = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected events for one operation whose accepting edge left cyc == b.
  task automatic push_op(input int b, input int stall, input logic ok, input logic with_done);
    ev_t e;
    for (int k = 0; k <= NB; k++) begin
      e.kind = 0;
      e.at   = b + 21 + 7 * k + ((k >= 1) ? stall : 0);
      e.ok   = 1'b0;
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.kind = 1;
      e.at   = b + 33 + 7 * NB + stall;
      e.ok   = ok;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_op(output int b, input logic hold);
    @(negedge clock);
    i_start = 1'b1;
    @(posedge clock);
    #1;
    b = cyc;
    if (!hold) i_start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    do @(negedge clock); while (cyc < c);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend_verdict) && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, o_ready, 1);
    chk({tag, "_round"}, o_round_count, 0);
    chk({tag, "_block"}, o_block_count, 0);
    chk({tag, "_outputs"}, out_vec, 13'h1000);
  endtask

  // Monitor: pops the scoreboard whenever a plaintext strobe or done appears.
  initial begin
    int kind;
    ev_t e;
    forever begin
      @(negedge clock);
      if (pend_verdict) begin
        chk("auth_ok", o_auth_ok, pend_ok);
        chk("auth_fail", o_auth_fail, !pend_ok);
        pend_verdict = 1'b0;
      end
      if (reset_n && (o_valid_plain || o_done)) begin
        kind = o_done ? 1 : 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_event_kind", kind, -1);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.at);
          if (o_done) begin
            pend_verdict = 1'b1;
            pend_ok      = e.ok;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int b;
    i_sys_enable = 1'b1;
    i_data_valid = 1'b1;
    i_tag_match  = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Nominal pass: plaintext strobes at 22/29/36/43, done at 55.
    start_op(b, 1'b0);
    push_op(b, 0, 1'b1, 1'b1);
    drain(200);

    // Tag mismatch gives a sticky fail verdict.
    i_tag_match = 1'b0;
    start_op(b, 1'b0);
    push_op(b, 0, 1'b0, 1'b1);
    drain(200);
    repeat (3) @(negedge clock);
    chk("fail_sticky_ok", o_auth_ok, 0);
    chk("fail_sticky_fail", o_auth_fail, 1);

    // Start held high: one op per IDLE visit; accept clears the old verdict.
    i_tag_match = 1'b1;
    start_op(b, 1'b1);
    chk("accept_clears_ok", o_auth_ok, 0);
    chk("accept_clears_fail", o_auth_fail, 0);
    push_op(b, 0, 1'b1, 1'b1);
    push_op(b + 56, 0, 1'b1, 1'b1);
    for (int n = 2; n <= 14; n++) begin
      wait_until(b + n - 1);
      chk("init_round_seq", o_round_count, (n <= 13) ? n - 2 : 11);
    end
    wait_until(b + 110);
    i_start = 1'b0;
    drain(300);
    repeat (30) @(negedge clock);
    chk("held_idle_ready", o_ready, 1);

    // Data stall before ciphertext block 2 delays everything by 5 cycles.
    start_op(b, 1'b0);
    push_op(b, 5, 1'b1, 1'b1);
    wait_until(b + 27);
    chk("stall_entry_ready", o_ready, 1);
    i_data_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_until(b + 28 + k);
      chk("stall_ready", o_ready, 1);
      chk("stall_round", o_round_count, 6);
      chk("stall_state_reg", o_enable_state_reg, 0);
    end
    i_data_valid = 1'b1;
    drain(200);

    // System disable during PROC_FINAL aborts without done.
    start_op(b, 1'b0);
    push_op(b, 0, 1'b1, 1'b0);
    wait_until(b + 45);
    chk("pre_abort_round", o_round_count, 3);
    i_sys_enable = 1'b0;
    wait_until(b + 46);
    chk("abort_ready", o_ready, 1);
    chk("abort_round_held", o_round_count, 3);
    chk("abort_block_held", o_block_count, 3);
    chk("abort_flags", {o_auth_ok, o_auth_fail}, 0);
    chk("abort_done", o_done, 0);
    wait_until(b + 48);
    i_sys_enable = 1'b1;
    wait_until(b + 70);
    chk("abort_queue_empty", exp_q.size(), 0);

    // Normal operation after the abort, then disable clears the verdict.
    start_op(b, 1'b0);
    push_op(b, 0, 1'b1, 1'b1);
    drain(200);
    chk("ok_before_disable", o_auth_ok, 1);
    @(negedge clock);
    i_sys_enable = 1'b0;
    @(negedge clock);
    chk("disable_clears_ok", o_auth_ok, 0);
    i_sys_enable = 1'b1;

    // Asynchronous reset during PROC_AD.
    start_op(b, 1'b0);
    wait_until(b + 16);
    chk("pre_reset_round", o_round_count, 8);
    chk("pre_reset_block", o_block_count, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("post_reset_queue", exp_q.size(), 0);
    chk("post_reset_ready", o_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
